writeback_regfile: RTL and testbench
====================================

// Module: writeback_regfile
// PURPOSE
//  - Write-back stage plus architectural register file; sits directly downstream of the memory/write-back pipeline register.
//  - Consumes that register's outputs: reg-write enable, 16-bit result and 3-bit destination. Commits the result into an 8 x 16 register file.
//  - Provides two combinational read ports to the decode stage.
//  - Keeps a retired-write counter for debug and performance visibility.
// PARAMETERS
//  - DATA_W  16  register and result width
//  - ADDR_W  3   register address width; NUM_REGS = 2**ADDR_W (local, derived)
//  - CNT_W   16  width of retired-write counter
// PORTS
//  - clk           in   1       single clock; all state updates on posedge
//  - rst           in   1       synchronous, active-high reset
//  - reg_write_in  in   1       write enable from the MW pipeline register
//  - wb_data_in    in   DATA_W  result to commit
//  - write_add_in  in   ADDR_W  destination register
//  - read_add1     in   ADDR_W  read port 1 address (decode stage)
//  - read_add2     in   ADDR_W  read port 2 address (decode stage)
//  - read_data1    out  DATA_W  read port 1 data, combinational
//  - read_data2    out  DATA_W  read port 2 data, combinational
//  - wb_count      out  CNT_W   number of committed writes since reset
// BEHAVIOUR
//  - Reset: on posedge clk with rst=1, all NUM_REGS entries clear to 0 and wb_count clears to 0.
//    Reset takes priority: a write presented in that cycle is discarded and not counted.
//  - After reset, read_data1/2 = 0 for every address.
//  - Write: on posedge clk with rst=0 and reg_write_in=1, regs[write_add_in] <= wb_data_in.
//    The write takes one cycle; the new value is visible on the read ports after that edge.
//  - reg_write_in=0: no register changes; wb_data_in and write_add_in are don't-care.
//  - All 8 registers are writable; R0 is not hardwired to zero.
//  - Reads: asynchronous/combinational from the array. Both ports may address the same register simultaneously.
//  - Counter: wb_count increments by 1 on each committed write.
//    Wraps 2**CNT_W-1 -> 0 with no flag and no saturation.
//  - No handshake or stall: one write per cycle maximum, and every enabled write commits.
//  - X on reg_write_in is treated as a design error; the model asserts reg_write_in is known when rst=0.
// CONFIGURATION
//  - Macro WB_BYPASS_EN
//    - Defined: write-through bypass. When reg_write_in=1 and read_addN == write_add_in, read_dataN = wb_data_in in the same cycle.
//      Bypass is gated off while rst=1.
//    - Undefined: a read of the register being written returns the old stored value; the new value appears the cycle after the edge.
//      The hazard unit must then cover this case with one stall or a forward.
// STRUCTURE
//  - Shared package pipeline_pkg holds:
//    - DATA_W, ADDR_W constants
//    - typedefs data_t (logic [DATA_W-1:0]) and reg_addr_t (logic [ADDR_W-1:0])
//  - One sub-module, regfile_core:
//    - storage array, synchronous clear and write, two asynchronous read ports
//  - Top level writeback_regfile adds:
//    - the optional bypass muxes
//    - the wb_count counter
// TESTING
//  - Reset: hold rst=1 two cycles with reg_write_in=1, wb_data_in=16'hBEEF, write_add_in=3
//    -> all reads 0, wb_count=0.
//  - Write/read: write R5=16'h1234, next cycle read_add1=5
//    -> read_data1=16'h1234, wb_count=1.
//  - Same-cycle hazard: write R2=16'hA5A5 while read_add2=2, with R2 previously 16'h0001
//    -> 16'h0001 without WB_BYPASS_EN, 16'hA5A5 with it; 16'hA5A5 in both builds the next cycle.
//  - Disabled write: reg_write_in=0, wb_data_in=16'hFFFF, write_add_in=7
//    -> R7 unchanged, wb_count unchanged.
//  - Counter wrap: force 65535 writes, then 1 more
//    -> wb_count 16'hFFFF then 16'h0000.
//  - Mid-operation reset: back-to-back writes R1..R4, assert rst on the R3 write
//    -> all regs 0 and wb_count=0 after that edge; the R4 write then yields wb_count=1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module   : pipeline_pkg
// Brief    : Shared datapath widths and register-file typedefs for the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

`default_nettype wire

// File: rtl/regfile_core.sv
// ============================================================================
// Module   : regfile_core
// Brief    : 2**ADDR_W x DATA_W storage, synchronous clear/write, two async reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_core
    import pipeline_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  reg_addr_t waddr,
    input  data_t     wdata,
    input  reg_addr_t raddr1,
    input  reg_addr_t raddr2,
    output data_t     rdata1,
    output data_t     rdata2
);

    localparam int NUM_REGS = 2**ADDR_W;

    data_t r_regs [NUM_REGS];

    // Every entry is writable, including R0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata1 = r_regs[raddr1];
    assign rdata2 = r_regs[raddr2];

endmodule

`default_nettype wire

// File: rtl/writeback_regfile.sv
// ============================================================================
// Module   : writeback_regfile
// Brief    : Write-back stage, architectural register file and retired-write
//            counter. Define WB_BYPASS_EN for same-cycle write-through reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_regfile
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_write_in,
    input  data_t            wb_data_in,
    input  reg_addr_t        write_add_in,
    input  reg_addr_t        read_add1,
    input  reg_addr_t        read_add2,
    output data_t            read_data1,
    output data_t            read_data2,
    output logic [CNT_W-1:0] wb_count
);

    data_t            w_core_data1;
    data_t            w_core_data2;
    logic [CNT_W-1:0] r_wb_count;

    regfile_core u_core (
        .clk    (clk),
        .rst    (rst),
        .we     (reg_write_in),
        .waddr  (write_add_in),
        .wdata  (wb_data_in),
        .raddr1 (read_add1),
        .raddr2 (read_add2),
        .rdata1 (w_core_data1),
        .rdata2 (w_core_data2)
    );

`ifdef WB_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    // Forward the in-flight result, but never while reset is discarding it.
    assign w_hit1     = !rst && reg_write_in && (read_add1 == write_add_in);
    assign w_hit2     = !rst && reg_write_in && (read_add2 == write_add_in);
    assign read_data1 = w_hit1 ? wb_data_in : w_core_data1;
    assign read_data2 = w_hit2 ? wb_data_in : w_core_data2;
`else
    assign read_data1 = w_core_data1;
    assign read_data2 = w_core_data2;
`endif

    // Free-running wrap on overflow; reset wins over a concurrent write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_count <= '0;
        end else if (reg_write_in) begin
            r_wb_count <= r_wb_count + 1'b1;
        end
    end

    assign wb_count = r_wb_count;

    a_we_known : assert property (@(posedge clk) !rst |-> !$isunknown(reg_write_in));

endmodule

`default_nettype wire

// File: tb/tb_writeback_regfile.sv
// ============================================================================
// Module   : tb_writeback_regfile
// Brief    : Scoreboard bench for writeback_regfile (either WB_BYPASS_EN build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_regfile;

    logic        clk;
    logic        rst;
    logic        reg_write_in;
    logic [15:0] wb_data_in;
    logic [2:0]  write_add_in;
    logic [2:0]  read_add1;
    logic [2:0]  read_add2;
    logic [15:0] read_data1;
    logic [15:0] read_data2;
    logic [15:0] wb_count;

    typedef struct {
        string       tag;
        int          sel;   // 0: read_data1, 1: read_data2, 2: wb_count
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t    sb_q[$];
    logic [15:0] m_regs [8];
    logic [15:0] m_cnt;
    int          n_checks;
    int          n_fail;

    writeback_regfile #(.CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_write_in (reg_write_in),
        .wb_data_in   (wb_data_in),
        .write_add_in (write_add_in),
        .read_add1    (read_add1),
        .read_add2    (read_add2),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .wb_count     (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] ra);
`ifdef WB_BYPASS_EN
        if (!rst && reg_write_in && ra == write_add_in) return wb_data_in;
`endif
        return m_regs[ra];
    endfunction

    function automatic void model_edge();
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
            m_cnt = 16'h0000;
        end else if (reg_write_in) begin
            m_regs[write_add_in] = wb_data_in;
            m_cnt = m_cnt + 16'h0001;
        end
    endfunction

    // Drive one cycle, score the pre-edge outputs, then advance the model.
    task automatic cycle(input logic r, input logic we, input logic [15:0] d,
                         input logic [2:0] wa, input logic [2:0] ra1,
                         input logic [2:0] ra2, input string tag);
        sb_item_t it;
        @(negedge clk);
        rst          = r;
        reg_write_in = we;
        wb_data_in   = d;
        write_add_in = wa;
        read_add1    = ra1;
        read_add2    = ra2;
        #1;
        sb_q.push_back('{tag: {tag, "_rd1"}, sel: 0, exp: model_read(ra1)});
        sb_q.push_back('{tag: {tag, "_rd2"}, sel: 1, exp: model_read(ra2)});
        sb_q.push_back('{tag: {tag, "_cnt"}, sel: 2, exp: m_cnt});
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            case (it.sel)
                0:       check_value(it.tag, read_data1, it.exp);
                1:       check_value(it.tag, read_data2, it.exp);
                default: check_value(it.tag, wb_count, it.exp);
            endcase
        end
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        m_cnt        = 16'h0000;
        rst          = 1'b1;
        reg_write_in = 1'b1;
        wb_data_in   = 16'hBEEF;
        write_add_in = 3'd3;
        read_add1    = 3'd0;
        read_add2    = 3'd0;

        // Reset held two cycles with a write pending: write is discarded.
        repeat (2) @(posedge clk);
        model_edge();
        for (int a = 0; a < 8; a += 2)
            cycle(1'b0, 1'b0, 16'h0000, 3'd0, 3'(a), 3'(a + 1), "reset_read");

        // Basic write then read.
        cycle(1'b0, 1'b1, 16'h1234, 3'd5, 3'd0, 3'd1, "wr_r5");
        cycle(1'b0, 1'b0, 16'h0000, 3'd0, 3'd5, 3'd3, "rd_r5");

        // Same-cycle hazard on read port 2 (outcome depends on bypass build).
        cycle(1'b0, 1'b1, 16'h0001, 3'd2, 3'd0, 3'd0, "wr_r2_old");
        cycle(1'b0, 1'b1, 16'hA5A5, 3'd2, 3'd5, 3'd2, "hazard");
        cycle(1'b0, 1'b0, 16'h0000, 3'd0, 3'd2, 3'd2, "hazard_next");

        // Disabled write leaves R7 and the counter alone.
        cycle(1'b0, 1'b1, 16'h7777, 3'd7, 3'd0, 3'd0, "wr_r7");
        cycle(1'b0, 1'b0, 16'hFFFF, 3'd7, 3'd7, 3'd7, "dis_wr");
        cycle(1'b0, 1'b0, 16'h0000, 3'd0, 3'd7, 3'd0, "dis_wr_after");

        // R0 is an ordinary register; port 1 sees the hazard too.
        cycle(1'b0, 1'b1, 16'h00C3, 3'd0, 3'd0, 3'd4, "wr_r0");
        cycle(1'b0, 1'b0, 16'h0000, 3'd0, 3'd0, 3'd0, "rd_r0");

        // Mid-operation reset lands on the R3 write.
        cycle(1'b0, 1'b1, 16'h1111, 3'd1, 3'd0, 3'd0, "mid_r1");
        cycle(1'b0, 1'b1, 16'h2222, 3'd2, 3'd1, 3'd0, "mid_r2");
        cycle(1'b1, 1'b1, 16'h3333, 3'd3, 3'd1, 3'd2, "mid_rst");
        cycle(1'b0, 1'b1, 16'h4444, 3'd4, 3'd1, 3'd3, "mid_r4");
        cycle(1'b0, 1'b0, 16'h0000, 3'd0, 3'd4, 3'd2, "mid_after");

        // Counter wrap: reset, 65535 writes, then one more.
        cycle(1'b1, 1'b0, 16'h0000, 3'd0, 3'd0, 3'd0, "wrap_rst");
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            rst          = 1'b0;
            reg_write_in = 1'b1;
            wb_data_in   = 16'(i);
            write_add_in = 3'(i);
            @(posedge clk);
            model_edge();
        end
        cycle(1'b0, 1'b0, 16'h0000, 3'd0, 3'd6, 3'd7, "wrap_ffff");
        cycle(1'b0, 1'b1, 16'hCAFE, 3'd1, 3'd0, 3'd0, "wrap_last");
        cycle(1'b0, 1'b0, 16'h0000, 3'd0, 3'd1, 3'd2, "wrap_zero");
        check_value("wrap_cnt_zero_const", wb_count, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
